serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
Controller that sequences a single-bit add cell, two half adders plus carry OR, over WIDTH-bit operands, one bit per clock, LSB first. It captures operands on a start handshake, runs the bit-serial loop with a registered carry, and presents a stable WIDTH-bit sum and carry-out with a one-cycle done pulse. This is the block that lets multi-bit additions reuse the team's 1-bit half-adder datapath instead of a parallel adder.

Parameters:
WIDTH, 8, operand/result width in bits (legal range 1..32)

Ports:
clk    input   1      system clock, rising-edge
rst    input   1      reset, asynchronous, active-high
start  input   1      request; sampled only in IDLE or DONE
a      input   WIDTH  operand A, captured on accepted start
b      input   WIDTH  operand B, captured on accepted start
busy   output  1      high while in RUN
done   output  1      one-cycle pulse when result becomes valid
sum    output  WIDTH  result register; changes only on completion
cout   output  1      carry-out of MSB; changes only on completion

Behaviour:
- Reset (async assert, any state): state=IDLE; busy=0, done=0, sum=0, cout=0; shift regs, carry, count cleared. Deassertion is assumed synchronous to clk externally.
- States: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. start=1 at an edge -> load sa<=a, sb<=b, c<=0, cnt<=0; next RUN.
- RUN: busy=1. Each edge: bit s = sa[0]^sb[0]^c; c <= (sa[0]&sb[0]) | (c&(sa[0]^sb[0])); acc <= {s, acc[WIDTH-1:1]}; sa, sb shift right; cnt++. When cnt reaches WIDTH-1 at an edge (last bit processed): sum <= final acc value including this bit, cout <= final carry; next DONE.
- DONE: done=1 for exactly this cycle, busy=0. start=1 -> accept new operands as in IDLE and go to RUN (back-to-back). Otherwise go to IDLE.
- Latency: start accepted at edge k -> exactly WIDTH RUN cycles -> done high in the cycle after edge k+WIDTH; sum/cout valid from that cycle and held until the next completion.
- start while in RUN: ignored, no queuing. a/b changes during RUN: no effect.
- Arithmetic: {cout,sum} = a + b, modulo 2^(WIDTH+1), unsigned.
- cnt width = clog2(WIDTH) with a minimum of 1. WIDTH=1: one RUN cycle.
- Reset mid-RUN: operation abandoned, no done pulse, sum/cout return to 0.

Decomposition:
- Shared package serial_pkg: state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2), helper function for cnt width.
- One natural sub-module: serial_fa_cell, combinational full-adder bit built from two half-adder stages. Ports x, y, cin, s, co. The controller instantiates one. Carry and all state registers stay in serial_adder_ctrl.

Test Plan:
- WIDTH=8, a=0x3C, b=0x5A, start pulse at edge k -> busy high 8 cycles, done in cycle after edge k+8, sum=0x96, cout=0.
- WIDTH=8, a=0xFF, b=0x01 -> sum=0x00, cout=1. Then a=0xFF, b=0xFF -> sum=0xFE, cout=1. Previous sum held until the new done.
- Start pulsed again 3 cycles into RUN with a=0x01, b=0x01 -> ignored; result still that of first operands; exactly one done pulse.
- start held high in the DONE cycle with a=0x10, b=0x20 -> busy reasserts next cycle without passing through IDLE; second done yields sum=0x30, cout=0.
- rst asserted mid-RUN, asynchronously between edges -> busy, done, sum, cout go 0 immediately; no done pulse afterwards; a new start gives a correct result.
- WIDTH=1, all four input combos (00, 01, 10, 11) -> {cout,sum} = 00, 01, 01, 10; done 1 cycle after each RUN cycle.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package serial_pkg;

    // Controller states; encodings are fixed so waveforms read the same across builds.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width: enough to count 0..w-1, never narrower than one bit.
    function automatic int cnt_width(input int w);
        int cw;
        cw = $clog2(w);
        return (cw < 1) ? 1 : cw;
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// One-bit full adder assembled from two half-adder stages and a carry OR.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle by the controller.
module serial_fa_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic s,
    output logic co
);

    logic w_s1;
    logic w_c1;
    logic w_c2;

    // First half adder: operand bits.
    assign w_s1 = x ^ y;
    assign w_c1 = x & y;

    // Second half adder: partial sum plus incoming carry.
    assign s    = w_s1 ^ cin;
    assign w_c2 = w_s1 & cin;

    // Either half adder may generate the carry, never both.
    assign co   = w_c1 | w_c2;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Sequences one full-adder cell over WIDTH-bit operands, LSB first, one bit per clock.
// Latency: start accepted at edge k -> done pulse in the cycle after edge k+WIDTH.
// Backpressure: start only honoured in IDLE/DONE; ignored (not queued) while busy.
module serial_adder_ctrl
    import serial_pkg::*;
#(
    parameter int WIDTH = 8   // legal range 1..32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;

    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_acc;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_load;
    logic             w_step;
    logic             w_last;
    logic             w_s;
    logic             w_co;
    logic [WIDTH-1:0] w_acc_next;

    // The single add cell; the carry it consumes and produces is registered here.
    serial_fa_cell u_fa (
        .x   (r_sa[0]),
        .y   (r_sb[0]),
        .cin (r_carry),
        .s   (w_s),
        .co  (w_co)
    );

    // New sum bit enters at the MSB so after WIDTH steps bit 0 sits at the LSB.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign w_acc_next = w_s;
        end else begin : g_acc_wn
            assign w_acc_next = {w_s, r_acc[WIDTH-1:1]};
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus status outputs; start only looked at outside RUN.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        w_last = 1'b0;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end
            end
            RUN: begin
                busy   = 1'b1;
                w_step = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                // Back-to-back: a new request skips IDLE entirely.
                if (start) begin
                    w_load = 1'b1;
                    w_next = RUN;
                end else begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand shifters, carry, accumulator and bit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_load) begin
            r_sa    <= a;
            r_sb    <= b;
            r_acc   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
        end else if (w_step) begin
            r_sa    <= r_sa >> 1;
            r_sb    <= r_sb >> 1;
            r_acc   <= w_acc_next;
            r_carry <= w_co;
            r_cnt   <= r_cnt + 1'b1;
        end
    end

    // Result registers only move on the final bit, so sum/cout hold between operations.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_step && w_last) begin
            r_sum  <= w_acc_next;
            r_cout <= w_co;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
